wildcard_match_table: RTL and testbench



---
 rtl/wildcard_match_table.sv | 237 +++++++++++++++++++++++
 tb/tb_wildcard_match_table.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wildcard_match_table.sv
// ---------------------------------------------------------------------------
// wildcard_match_table
//
// Runtime-programmable wildcard pattern matcher. Holds DEPTH entries of
// {value, care-mask, enable}. A control agent writes and reads entries through
// an address port that flags out-of-range addresses. A streaming client
// searches the table through a valid/ready lookup port. Each lookup returns:
//   - a hit flag,
//   - the lowest matching index,
//   - the per-entry match vector,
//   - optionally, the match count.
//
// Optional feature macro: WILDCARD_MATCH_COUNT_EN
//   defined   -> o_rsp_count carries the popcount of the match vector
//   undefined -> popcount logic omitted, o_rsp_count tied to 0
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_wr_en/addr/value/care     table write strobe and data
//   o_wr_oob                    one-cycle pulse after an out-of-range write
//   i_rd_en/addr                table read strobe and address
//   o_rd_valid/value/care/oob   registered read-back (latency 1)
//   i_req_valid/o_req_ready     lookup request handshake, i_req_key = key
//   o_rsp_valid/i_rsp_ready     lookup response handshake
//   o_rsp_hit/index/vec/count   lookup result (latency 1)
//   o_oob_count                 saturating count of out-of-range accesses
// ---------------------------------------------------------------------------
module wildcard_match_table #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_value,
  input  logic [WIDTH-1:0]  i_wr_care,
  output logic              o_wr_oob,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [WIDTH-1:0]  o_rd_value,
  output logic [WIDTH-1:0]  o_rd_care,
  output logic              o_rd_oob,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [WIDTH-1:0]  i_req_key,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_hit,
  output logic [ADDR_W-1:0] o_rsp_index,
  output logic [DEPTH-1:0]  o_rsp_vec,
  output logic [CNT_W-1:0]  o_rsp_count,
  output logic [7:0]        o_oob_count
);

  localparam int unsigned DEPTH_U = DEPTH;

  logic [WIDTH-1:0]  r_value [DEPTH];
  logic [WIDTH-1:0]  r_care  [DEPTH];
  logic [DEPTH-1:0]  r_enable;
  logic              r_outOfReset;
  logic              r_wrOob;
  logic              r_rdValid;
  logic [WIDTH-1:0]  r_rdValue;
  logic [WIDTH-1:0]  r_rdCare;
  logic              r_rdOob;
  logic              r_rspValid;
  logic              r_rspHit;
  logic [ADDR_W-1:0] r_rspIndex;
  logic [DEPTH-1:0]  r_rspVec;
  logic [7:0]        r_oobCount;

  logic              w_wrInRange;
  logic              w_rdInRange;
  logic              w_wrOob;
  logic              w_rdOob;
  logic              w_accept;
  logic [DEPTH-1:0]  w_matchVec;
  logic [ADDR_W-1:0] w_hitIndex;
  logic [WIDTH-1:0]  w_rdValue;
  logic [WIDTH-1:0]  w_rdCare;
  logic [8:0]        w_oobSum;

  // Compare at 32 bits so that addresses wider than the table are range-checked
  assign w_wrInRange = (32'(i_wr_addr) < DEPTH_U);
  assign w_rdInRange = (32'(i_rd_addr) < DEPTH_U);
  assign w_wrOob     = i_wr_en & ~w_wrInRange;
  assign w_rdOob     = i_rd_en & ~w_rdInRange;

  // r_outOfReset keeps ready low while reset is held and for the reset edge itself
  assign o_req_ready = r_outOfReset & (~r_rspValid | i_rsp_ready);
  assign w_accept    = i_req_valid & o_req_ready;

  // Table storage: a write to a valid address stores the pattern and enables the entry
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_value[i] <= '0;
        r_care[i]  <= '0;
      end
      r_enable <= '0;
    end else if (i_wr_en && w_wrInRange) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_addr == ADDR_W'(i)) begin
          r_value[i]  <= i_wr_value;
          r_care[i]   <= i_wr_care;
          r_enable[i] <= 1'b1;
        end
      end
    end
  end

  // Per-entry match against the current (pre-write) table contents
  always_comb begin
    w_matchVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_matchVec[i] = r_enable[i] & (((i_req_key ^ r_value[i]) & r_care[i]) == '0);
    end
  end

  // Priority encoder: scanning downward leaves the lowest matching index
  always_comb begin
    w_hitIndex = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_matchVec[i]) begin
        w_hitIndex = ADDR_W'(i);
      end
    end
  end

  // Read mux; out-of-range addresses return zeros
  always_comb begin
    w_rdValue = '0;
    w_rdCare  = '0;
    if (w_rdInRange) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_rd_addr == ADDR_W'(i)) begin
          w_rdValue = r_value[i];
          w_rdCare  = r_care[i];
        end
      end
    end
  end

  // Read-back registers: valid pulses once per strobe, data is held between strobes
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdValid <= 1'b0;
      r_rdValue <= '0;
      r_rdCare  <= '0;
      r_rdOob   <= 1'b0;
    end else begin
      r_rdValid <= i_rd_en;
      if (i_rd_en) begin
        r_rdValue <= w_rdValue;
        r_rdCare  <= w_rdCare;
        r_rdOob   <= ~w_rdInRange;
      end
    end
  end

  // Out-of-range bookkeeping. The sum is 9 bits wide so that a double bump
  // near the top is caught and clamped to 255 instead of wrapping.
  assign w_oobSum = {1'b0, r_oobCount} + {8'd0, w_wrOob} + {8'd0, w_rdOob};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wrOob    <= 1'b0;
      r_oobCount <= '0;
    end else begin
      r_wrOob    <= w_wrOob;
      r_oobCount <= w_oobSum[8] ? 8'hFF : w_oobSum[7:0];
    end
  end

  // Lookup response register: loaded on accept, held under backpressure,
  // dropped once the consumer takes it without a new request behind it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_outOfReset <= 1'b0;
      r_rspValid   <= 1'b0;
      r_rspHit     <= 1'b0;
      r_rspIndex   <= '0;
      r_rspVec     <= '0;
    end else begin
      r_outOfReset <= 1'b1;
      if (w_accept) begin
        r_rspValid <= 1'b1;
        r_rspHit   <= |w_matchVec;
        r_rspIndex <= w_hitIndex;
        r_rspVec   <= w_matchVec;
      end else if (i_rsp_ready) begin
        r_rspValid <= 1'b0;
      end
    end
  end

`ifdef WILDCARD_MATCH_COUNT_EN
  logic [CNT_W-1:0] w_matchCount;
  logic [CNT_W-1:0] r_rspCount;

  always_comb begin
    w_matchCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_matchCount = w_matchCount + CNT_W'(w_matchVec[i]);
    end
  end

  // Match count travels with the rest of the response
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rspCount <= '0;
    end else if (w_accept) begin
      r_rspCount <= w_matchCount;
    end
  end

  assign o_rsp_count = r_rspCount;
`else
  assign o_rsp_count = '0;
`endif

  assign o_wr_oob    = r_wrOob;
  assign o_rd_valid  = r_rdValid;
  assign o_rd_value  = r_rdValue;
  assign o_rd_care   = r_rdCare;
  assign o_rd_oob    = r_rdOob;
  assign o_rsp_valid = r_rspValid;
  assign o_rsp_hit   = r_rspHit;
  assign o_rsp_index = r_rspIndex;
  assign o_rsp_vec   = r_rspVec;
  assign o_oob_count = r_oobCount;

endmodule

// File: tb/tb_wildcard_match_table.sv
// ---------------------------------------------------------------------------
// tb_wildcard_match_table
//
// Directed bench for wildcard_match_table (WIDTH=8, DEPTH=4, ADDR_W=4).
// A behavioural table model predicts every output. It is checked on each
// falling edge. Hand-computed literals after key vectors pin the model.
// ---------------------------------------------------------------------------
module tb_wildcard_match_table;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_wr_en;
  logic [3:0] i_wr_addr;
  logic [7:0] i_wr_value;
  logic [7:0] i_wr_care;
  logic       o_wr_oob;
  logic       i_rd_en;
  logic [3:0] i_rd_addr;
  logic       o_rd_valid;
  logic [7:0] o_rd_value;
  logic [7:0] o_rd_care;
  logic       o_rd_oob;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [7:0] i_req_key;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic       o_rsp_hit;
  logic [3:0] o_rsp_index;
  logic [3:0] o_rsp_vec;
  logic [2:0] o_rsp_count;
  logic [7:0] o_oob_count;

`ifdef WILDCARD_MATCH_COUNT_EN
  localparam int CountEnabled = 1;
`else
  localparam int CountEnabled = 0;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit checkOn    = 1'b0;

  wildcard_match_table #(.WIDTH(8), .DEPTH(4), .ADDR_W(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_value  (i_wr_value),
    .i_wr_care   (i_wr_care),
    .o_wr_oob    (o_wr_oob),
    .i_rd_en     (i_rd_en),
    .i_rd_addr   (i_rd_addr),
    .o_rd_valid  (o_rd_valid),
    .o_rd_value  (o_rd_value),
    .o_rd_care   (o_rd_care),
    .o_rd_oob    (o_rd_oob),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_key   (i_req_key),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_hit   (o_rsp_hit),
    .o_rsp_index (o_rsp_index),
    .o_rsp_vec   (o_rsp_vec),
    .o_rsp_count (o_rsp_count),
    .o_oob_count (o_oob_count)
  );

  // 10-unit clock period
  always #5 i_clk = ~i_clk;

  // Shared comparison: counts every check and reports any difference
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one full input vector just after a falling edge. Return once the
  // resulting registered outputs are visible on the next falling edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic [3:0] wa,
                               input logic [7:0] wv, input logic [7:0] wc,
                               input logic re, input logic [3:0] ra,
                               input logic rv, input logic [7:0] key, input logic rr);
    i_rst_n     = rst;
    i_wr_en     = we;
    i_wr_addr   = wa;
    i_wr_value  = wv;
    i_wr_care   = wc;
    i_rd_en     = re;
    i_rd_addr   = ra;
    i_req_valid = rv;
    i_req_key   = key;
    i_rsp_ready = rr;
    @(negedge i_clk);
    #1;
  endtask

  // Behavioural model: table as plain arrays, the response as a single slot
  logic [7:0] mValue [4];
  logic [7:0] mCare  [4];
  bit         mEn    [4];
  bit         mOut, mRspValid, mRspHit, mRdValid, mRdOob, mWrOob;
  int         mRspIndex, mRspCount, mOobCount;
  logic [3:0] mRspVec;
  logic [7:0] mRdValue, mRdCare;

  always @(posedge i_clk) begin : modelStep
    bit accept;
    int bump;
    int a;
    if (!i_rst_n) begin
      for (int e = 0; e < 4; e++) begin
        mValue[e] = 8'h00;
        mCare[e]  = 8'h00;
        mEn[e]    = 1'b0;
      end
      mOut = 0; mRspValid = 0; mRspHit = 0; mRspIndex = 0; mRspVec = 0; mRspCount = 0;
      mRdValid = 0; mRdOob = 0; mRdValue = 0; mRdCare = 0; mWrOob = 0; mOobCount = 0;
    end else begin
      accept = i_req_valid && mOut && (!mRspValid || i_rsp_ready);
      bump   = 0;
      mRdValid = i_rd_en;
      if (i_rd_en) begin
        a = int'(i_rd_addr);
        if (a < 4) begin
          mRdValue = mValue[a];
          mRdCare  = mCare[a];
          mRdOob   = 0;
        end else begin
          mRdValue = 8'h00;
          mRdCare  = 8'h00;
          mRdOob   = 1;
          bump++;
        end
      end
      mWrOob = i_wr_en && (int'(i_wr_addr) >= 4);
      if (mWrOob) bump++;
      if (accept) begin
        mRspValid = 1; mRspHit = 0; mRspIndex = 0; mRspVec = 0; mRspCount = 0;
        for (int e = 0; e < 4; e++) begin
          if (mEn[e] && ((i_req_key & mCare[e]) == (mValue[e] & mCare[e]))) begin
            mRspVec[e] = 1'b1;
            mRspCount++;
          end
        end
        for (int e = 3; e >= 0; e--) begin
          if (mRspVec[e]) begin
            mRspHit   = 1;
            mRspIndex = e;
          end
        end
        if (CountEnabled == 0) mRspCount = 0;
      end else if (i_rsp_ready) begin
        mRspValid = 0;
      end
      if (i_wr_en && (int'(i_wr_addr) < 4)) begin
        a = int'(i_wr_addr);
        mValue[a] = i_wr_value;
        mCare[a]  = i_wr_care;
        mEn[a]    = 1'b1;
      end
      mOobCount = (mOobCount + bump > 255) ? 255 : mOobCount + bump;
      mOut = 1;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge i_clk) begin
    if (checkOn) begin
      checkOutput("req_ready", 32'(o_req_ready), 32'(mOut && (!mRspValid || i_rsp_ready)));
      checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(mRspValid));
      if (mRspValid) begin
        checkOutput("rsp_hit",   32'(o_rsp_hit),   32'(mRspHit));
        checkOutput("rsp_index", 32'(o_rsp_index), 32'(mRspIndex));
        checkOutput("rsp_vec",   32'(o_rsp_vec),   32'(mRspVec));
        checkOutput("rsp_count", 32'(o_rsp_count), 32'(mRspCount));
      end
      checkOutput("rd_valid", 32'(o_rd_valid), 32'(mRdValid));
      if (mRdValid) begin
        checkOutput("rd_value", 32'(o_rd_value), 32'(mRdValue));
        checkOutput("rd_care",  32'(o_rd_care),  32'(mRdCare));
        checkOutput("rd_oob",   32'(o_rd_oob),   32'(mRdOob));
      end
      checkOutput("wr_oob",    32'(o_wr_oob),    32'(mWrOob));
      checkOutput("oob_count", 32'(o_oob_count), 32'(mOobCount));
    end
  end

  // Directed scenario with literal expectations after the key vectors
  initial begin
    $display("[TB] wildcard_match_table bench start (count feature = %0d)", CountEnabled);
    applyStimulus(0, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 8'h00, 1);
    checkOn = 1'b1;
    applyStimulus(0, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'h00, 1);
    checkOutput("lit_reset_ready",  32'(o_req_ready), 0);
    checkOutput("lit_reset_rspv",   32'(o_rsp_valid), 0);
    checkOutput("lit_reset_oobcnt", 32'(o_oob_count), 0);
    checkOutput("lit_reset_rdv",    32'(o_rd_valid),  0);

    // First cycle out of reset: ready rises
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 8'h00, 1);
    checkOutput("lit_ready_after_reset", 32'(o_req_ready), 1);

    // Entry0 = 0101_?10? : key 5D hits, key 5E misses
    applyStimulus(1, 1, 4'd0, 8'h54, 8'hF6, 0, 4'd0, 0, 8'h00, 1);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'h5D, 1);
    checkOutput("lit_5D_hit", 32'(o_rsp_hit),   1);
    checkOutput("lit_5D_idx", 32'(o_rsp_index), 0);
    checkOutput("lit_5D_vec", 32'(o_rsp_vec),   32'h1);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'h5E, 1);
    checkOutput("lit_5E_hit", 32'(o_rsp_hit),   0);
    checkOutput("lit_5E_idx", 32'(o_rsp_index), 0);
    checkOutput("lit_5E_vec", 32'(o_rsp_vec),   0);

    // Entry1 exact A5, entry2 full wildcard: key A5 hits both, index 1
    applyStimulus(1, 1, 4'd1, 8'hA5, 8'hFF, 0, 4'd0, 0, 8'h00, 1);
    applyStimulus(1, 1, 4'd2, 8'h3C, 8'h00, 0, 4'd0, 0, 8'h00, 1);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'hA5, 1);
    checkOutput("lit_A5_hit", 32'(o_rsp_hit),   1);
    checkOutput("lit_A5_idx", 32'(o_rsp_index), 1);
    checkOutput("lit_A5_vec", 32'(o_rsp_vec),   32'h6);
    checkOutput("lit_A5_cnt", 32'(o_rsp_count), (CountEnabled != 0) ? 2 : 0);

    // Out-of-range write then out-of-range read
    applyStimulus(1, 1, 4'd9, 8'hEE, 8'hEE, 0, 4'd0, 0, 8'h00, 1);
    checkOutput("lit_wr_oob",  32'(o_wr_oob),    1);
    checkOutput("lit_oobcnt1", 32'(o_oob_count), 1);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 1, 4'd4, 1, 8'hA5, 1);
    checkOutput("lit_wr_oob_drop", 32'(o_wr_oob),    0);
    checkOutput("lit_rd_oob",      32'(o_rd_oob),    1);
    checkOutput("lit_rd_oob_val",  32'(o_rd_value),  0);
    checkOutput("lit_oobcnt2",     32'(o_oob_count), 2);
    checkOutput("lit_table_kept",  32'(o_rsp_vec),   32'h6);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 1, 4'd1, 0, 8'h00, 1);
    checkOutput("lit_rd1_value", 32'(o_rd_value), 32'hA5);
    checkOutput("lit_rd1_care",  32'(o_rd_care),  32'hFF);

    // Backpressure: pending 5D response held for 3 cycles, then release
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'h5D, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'hA5, 0);
      checkOutput("lit_bp_ready", 32'(o_req_ready), 0);
      checkOutput("lit_bp_vec",   32'(o_rsp_vec),   32'h5);
    end
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'hA5, 1);
    checkOutput("lit_release_idx", 32'(o_rsp_index), 1);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 8'h00, 1);
    checkOutput("lit_no_dup", 32'(o_rsp_valid), 0);

    // Same-cycle write and lookup sees the old table
    applyStimulus(1, 1, 4'd2, 8'h00, 8'hFF, 0, 4'd0, 0, 8'h00, 1);
    applyStimulus(1, 1, 4'd0, 8'hFF, 8'hFF, 0, 4'd0, 1, 8'hFF, 1);
    checkOutput("lit_old_miss", 32'(o_rsp_hit), 0);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'hFF, 1);
    checkOutput("lit_new_hit", 32'(o_rsp_hit),   1);
    checkOutput("lit_new_idx", 32'(o_rsp_index), 0);

    // Same-cycle read and write of one address returns the old data
    applyStimulus(1, 1, 4'd0, 8'h11, 8'h22, 1, 4'd0, 0, 8'h00, 1);
    checkOutput("lit_rw_old", 32'(o_rd_value), 32'hFF);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 1, 4'd0, 0, 8'h00, 1);
    checkOutput("lit_rw_new", 32'(o_rd_care), 32'h22);

    // Double out-of-range bumps push the counter to saturation
    for (int k = 0; k < 130; k++) begin
      applyStimulus(1, 1, 4'd15, 8'h00, 8'h00, 1, 4'd8, 0, 8'h00, 1);
    end
    checkOutput("lit_oob_sat", 32'(o_oob_count), 255);

    // Reset with a pending response and a programmed table
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 1, 4'd1, 1, 8'h00, 0);
    checkOutput("lit_pre_reset_rspv", 32'(o_rsp_valid), 1);
    applyStimulus(0, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 8'h00, 0);
    checkOutput("lit_mid_rspv",   32'(o_rsp_valid), 0);
    checkOutput("lit_mid_ready",  32'(o_req_ready), 0);
    checkOutput("lit_mid_oobcnt", 32'(o_oob_count), 0);
    checkOutput("lit_mid_rdval",  32'(o_rd_value),  0);
    checkOutput("lit_mid_vec",    32'(o_rsp_vec),   0);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 8'h00, 1);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 8'h00, 1);
    checkOutput("lit_post_reset_hit", 32'(o_rsp_hit), 0);
    checkOutput("lit_post_reset_vec", 32'(o_rsp_vec), 0);
    applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 8'h00, 1);

    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
